// File: rtl/ram_block_mover.sv
// Purpose: command-driven fill / copy / check sequencer for one port of a RamDX_Fpga dual-port RAM.
// Latency: fill N+1, copy 2N+1, check N+2, no-op 1 enabled cycles from start to ADone.
// Backpressure: none; ACmdStart is ignored while busy and AClkAEn low freezes all state. Option: RAM_MOVER_CSUM_EN adds ACsum.
module ram_block_mover #(
    parameter int CAddrLen = 11,
    parameter int CDataLen = 8
) (
    input  logic                AClkA,
    input  logic                AResetAN,
    input  logic                AClkAEn,
    input  logic                ACmdStart,
    input  logic [1:0]          ACmdOp,
    input  logic [CAddrLen-1:0] ACmdSrc,
    input  logic [CAddrLen-1:0] ACmdDst,
    input  logic [CAddrLen:0]   ACmdLen,
    input  logic [CDataLen-1:0] ACmdData,
    output logic                ABusy,
    output logic                ADone,
    output logic                AErr,
`ifdef RAM_MOVER_CSUM_EN
    output logic [CDataLen-1:0] ACsum,
`endif
    output logic [CAddrLen-1:0] ARamAddr,
    output logic [CDataLen-1:0] ARamMosi,
    output logic                ARamWrEn,
    output logic                ARamRdEn,
    input  logic [CDataLen-1:0] ARamMiso
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FILL,
        S_CP_RD,
        S_CP_WR,
        S_CHK,
        S_CHK_LAST,
        S_DONE
    } state_t;

    state_t                state_q, state_d;
    logic [CAddrLen-1:0]   src_q, src_d;
    logic [CAddrLen-1:0]   dst_q, dst_d;
    logic [CAddrLen:0]     cnt_q, cnt_d;
    logic [CDataLen-1:0]   pat_q, pat_d;
    logic                  err_q, err_d;
    logic [CAddrLen-1:0]   addr_q, addr_d;
    logic                  rd_pend_q, rd_pend_d;
    logic                  accept;
    logic                  last_word;
`ifdef RAM_MOVER_CSUM_EN
    logic [CDataLen-1:0]   csum_q, csum_d;
`endif

    assign accept    = ACmdStart && (state_q == S_IDLE || state_q == S_DONE);
    assign last_word = (cnt_q == (CAddrLen+1)'(1));
    assign AErr      = err_q;
`ifdef RAM_MOVER_CSUM_EN
    assign ACsum     = csum_q;
`endif

    always_comb begin
        state_d   = state_q;
        src_d     = src_q;
        dst_d     = dst_q;
        cnt_d     = cnt_q;
        pat_d     = pat_q;
        err_d     = err_q;
        ABusy     = 1'b0;
        ADone     = 1'b0;
        ARamAddr  = addr_q;
        ARamMosi  = '0;
        ARamWrEn  = 1'b0;
        ARamRdEn  = 1'b0;

        case (state_q)
            S_FILL: begin
                ABusy    = 1'b1;
                ARamWrEn = 1'b1;
                ARamAddr = dst_q;
                ARamMosi = pat_q;
                dst_d    = dst_q + CAddrLen'(1);
                cnt_d    = cnt_q - (CAddrLen+1)'(1);
                if (last_word) state_d = S_DONE;
            end
            S_CP_RD: begin
                ABusy    = 1'b1;
                ARamRdEn = 1'b1;
                ARamAddr = src_q;
                state_d  = S_CP_WR;
            end
            S_CP_WR: begin
                ABusy    = 1'b1;
                ARamWrEn = 1'b1;
                ARamAddr = dst_q;
                ARamMosi = ARamMiso;
                src_d    = src_q + CAddrLen'(1);
                dst_d    = dst_q + CAddrLen'(1);
                cnt_d    = cnt_q - (CAddrLen+1)'(1);
                state_d  = last_word ? S_DONE : S_CP_RD;
            end
            S_CHK: begin
                ABusy    = 1'b1;
                ARamRdEn = 1'b1;
                ARamAddr = dst_q;
                dst_d    = dst_q + CAddrLen'(1);
                cnt_d    = cnt_q - (CAddrLen+1)'(1);
                state_d  = last_word ? S_CHK_LAST : S_CHK;
            end
            S_CHK_LAST: begin
                ABusy    = 1'b1;
                state_d  = S_DONE;
            end
            S_DONE: begin
                ADone    = 1'b1;
                state_d  = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A check read issued last cycle returns its word now; compare against the pattern.
        rd_pend_d = (state_q == S_CHK);
        if (rd_pend_q && (ARamMiso != pat_q)) err_d = 1'b1;
        addr_d = ARamAddr;

        if (accept) begin
            src_d = ACmdSrc;
            dst_d = ACmdDst;
            cnt_d = ACmdLen;
            pat_d = ACmdData;
            err_d = 1'b0;
            if (ACmdLen == '0 || ACmdOp == 2'b11) begin
                state_d = S_DONE;
            end else begin
                case (ACmdOp)
                    2'b00:   state_d = S_FILL;
                    2'b01:   state_d = S_CP_RD;
                    default: state_d = S_CHK;
                endcase
            end
        end
    end

`ifdef RAM_MOVER_CSUM_EN
    always_comb begin
        csum_d = csum_q;
        if (ARamWrEn)       csum_d = csum_q + ARamMosi;
        else if (rd_pend_q) csum_d = csum_q + ARamMiso;
        if (accept)         csum_d = '0;
    end

    always_ff @(posedge AClkA or negedge AResetAN) begin
        if (!AResetAN) begin
            csum_q <= '0;
        end else if (AClkAEn) begin
            csum_q <= csum_d;
        end
    end
`endif

    always_ff @(posedge AClkA or negedge AResetAN) begin
        if (!AResetAN) begin
            state_q   <= S_IDLE;
            src_q     <= '0;
            dst_q     <= '0;
            cnt_q     <= '0;
            pat_q     <= '0;
            err_q     <= 1'b0;
            addr_q    <= '0;
            rd_pend_q <= 1'b0;
        end else if (AClkAEn) begin
            state_q   <= state_d;
            src_q     <= src_d;
            dst_q     <= dst_d;
            cnt_q     <= cnt_d;
            pat_q     <= pat_d;
            err_q     <= err_d;
            addr_q    <= addr_d;
            rd_pend_q <= rd_pend_d;
        end
    end

endmodule
